uart_cmd_decoder: RTL and testbench

- Receives host command frames from the UART receiver and applies the capture configuration: trigger mask, sample-clock divider, arm and abort.
- Returns a 1–2 byte response per frame through the shared UART transmitter. It borrows the transmitter from the FIFO dump controller with a req/gnt handshake.
- Sits between the UART core and the trigger block, sample divider and dump controller.

---
 rtl/uart_cmd_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Host command frame decoder: parses HEADER/OPCODE/PAYLOAD/CHK frames from the UART
// receiver, applies capture configuration and returns an ACK/NAK (+status) response.
module uart_cmd_decoder #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [15:0] DIV_RESET      = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_rxdata,
  input  logic        uart_rxempty,
  output logic        uart_uld_rx_data,
  input  logic        uart_txempty,
  output logic [7:0]  uart_tx_data,
  output logic        uart_ld_tx_data,
  output logic        resp_req,
  input  logic        resp_gnt,
  input  logic        capture_busy,
  output logic [2:0]  trig_mask,
  output logic [15:0] samp_div,
  output logic        arm,
  output logic        abort
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    S_HUNT, S_OPCODE, S_PAYLOAD, S_CHECK, S_EXEC, S_RESP_REQ, S_RESP_LOAD, S_RESP_WAIT
  } state_t;

  state_t        state_q;
  logic [7:0]    op_q, pay0_q, pay1_q, xor_q, resp0_q, resp1_q, tx_data_q;
  logic [1:0]    plen_q, pcnt_q;
  logic [TW-1:0] tcnt_q;
  logic          two_q, idx_q;
  logic          uld_q, ld_q, req_q, arm_q, abort_q;
  logic [2:0]    mask_q;
  logic [15:0]   div_q;

  logic          intake_d, byte_vld_d, tmo_d;
  logic [15:0]   div_d;

  // Bytes are only taken in parsing states, and never on the cycle right after an unload,
  // so the receiver has time to update its empty flag.
  assign intake_d   = (state_q == S_HUNT) || (state_q == S_OPCODE) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign byte_vld_d = intake_d && !uart_rxempty && !uld_q;
  assign tmo_d      = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign div_d      = {pay0_q, pay1_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_HUNT;
      op_q      <= '0;
      pay0_q    <= '0;
      pay1_q    <= '0;
      xor_q     <= '0;
      resp0_q   <= '0;
      resp1_q   <= '0;
      tx_data_q <= '0;
      plen_q    <= '0;
      pcnt_q    <= '0;
      tcnt_q    <= '0;
      two_q     <= 1'b0;
      idx_q     <= 1'b0;
      uld_q     <= 1'b0;
      ld_q      <= 1'b0;
      req_q     <= 1'b0;
      arm_q     <= 1'b0;
      abort_q   <= 1'b0;
      mask_q    <= 3'b111;
      div_q     <= DIV_RESET;
    end else begin
      uld_q   <= 1'b0;
      arm_q   <= 1'b0;
      abort_q <= 1'b0;
      tcnt_q  <= '0;
      case (state_q)
        S_HUNT: begin
          if (byte_vld_d) begin
            uld_q <= 1'b1;
            if (uart_rxdata == HEADER) state_q <= S_OPCODE;
          end
        end
        S_OPCODE: begin
          if (byte_vld_d) begin
            uld_q  <= 1'b1;
            op_q   <= uart_rxdata;
            xor_q  <= uart_rxdata;
            pcnt_q <= '0;
            case (uart_rxdata)
              8'h01:                begin plen_q <= 2'd1; state_q <= S_PAYLOAD; end
              8'h02:                begin plen_q <= 2'd2; state_q <= S_PAYLOAD; end
              8'h03, 8'h04, 8'h05:  begin plen_q <= 2'd0; state_q <= S_CHECK;   end
              default: begin
                resp0_q <= NAK;
                two_q   <= 1'b0;
                idx_q   <= 1'b0;
                req_q   <= 1'b1;
                state_q <= S_RESP_REQ;
              end
            endcase
          end else if (tmo_d) begin
            state_q <= S_HUNT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (byte_vld_d) begin
            uld_q  <= 1'b1;
            xor_q  <= xor_q ^ uart_rxdata;
            pcnt_q <= pcnt_q + 2'd1;
            if (pcnt_q == 2'd0) pay0_q <= uart_rxdata;
            else                pay1_q <= uart_rxdata;
            if ((pcnt_q + 2'd1) == plen_q) state_q <= S_CHECK;
          end else if (tmo_d) begin
            state_q <= S_HUNT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (byte_vld_d) begin
            uld_q <= 1'b1;
            if (uart_rxdata == xor_q) begin
              state_q <= S_EXEC;
            end else begin
              resp0_q <= NAK;
              two_q   <= 1'b0;
              idx_q   <= 1'b0;
              req_q   <= 1'b1;
              state_q <= S_RESP_REQ;
            end
          end else if (tmo_d) begin
            state_q <= S_HUNT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          resp0_q <= ACK;
          two_q   <= 1'b0;
          idx_q   <= 1'b0;
          req_q   <= 1'b1;
          state_q <= S_RESP_REQ;
          case (op_q)
            8'h01: if (capture_busy) resp0_q <= NAK; else mask_q <= pay0_q[2:0];
            8'h02: if (capture_busy || div_d == 16'd0) resp0_q <= NAK; else div_q <= div_d;
            8'h03: if (capture_busy) resp0_q <= NAK; else arm_q <= 1'b1;
            8'h04: abort_q <= 1'b1;
            8'h05: begin
              two_q   <= 1'b1;
              resp1_q <= {capture_busy, 4'b0000, mask_q};
            end
            default: resp0_q <= NAK;
          endcase
        end
        S_RESP_REQ: begin
          if (resp_gnt) state_q <= S_RESP_LOAD;
        end
        S_RESP_LOAD: begin
          // Load strobe is held until the transmitter reports it took the byte.
          if (ld_q) begin
            if (!uart_txempty) begin
              ld_q    <= 1'b0;
              state_q <= S_RESP_WAIT;
            end
          end else if (uart_txempty) begin
            ld_q      <= 1'b1;
            tx_data_q <= idx_q ? resp1_q : resp0_q;
          end
        end
        S_RESP_WAIT: begin
          if (uart_txempty) begin
            if (two_q && !idx_q) begin
              idx_q   <= 1'b1;
              state_q <= S_RESP_LOAD;
            end else begin
              req_q   <= 1'b0;
              state_q <= S_HUNT;
            end
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign uart_uld_rx_data = uld_q;
  assign uart_tx_data     = tx_data_q;
  assign uart_ld_tx_data  = ld_q & resp_gnt;
  assign resp_req         = req_q;
  assign trig_mask        = mask_q;
  assign samp_div         = div_q;
  assign arm              = arm_q;
  assign abort            = abort_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized frame stimulus against a frame-level command model, with UART rx/tx and grant models.
module tb_uart_cmd_decoder;

  localparam int TO = 300;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk, rst;
  logic [7:0]  uart_rxdata;
  logic        uart_rxempty, uart_uld_rx_data, uart_txempty;
  logic [7:0]  uart_tx_data;
  logic        uart_ld_tx_data, resp_req, resp_gnt, capture_busy;
  logic [2:0]  trig_mask;
  logic [15:0] samp_div;
  logic        arm, abort;

  uart_cmd_decoder #(.HEADER(8'hA5), .TIMEOUT_CYCLES(TO), .DIV_RESET(16'd1)) dut (
    .clk(clk), .rst(rst),
    .uart_rxdata(uart_rxdata), .uart_rxempty(uart_rxempty), .uart_uld_rx_data(uart_uld_rx_data),
    .uart_txempty(uart_txempty), .uart_tx_data(uart_tx_data), .uart_ld_tx_data(uart_ld_tx_data),
    .resp_req(resp_req), .resp_gnt(resp_gnt), .capture_busy(capture_busy),
    .trig_mask(trig_mask), .samp_div(samp_div), .arm(arm), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, viol = 0;
  logic [7:0] rxq[$], txq[$], exp_q[$];
  int tx_cnt, gdly, arm_cnt, abort_cnt;
  logic tx_hold, arm_prev, abort_prev, uld_prev;
  logic [2:0]  m_mask;
  logic [15:0] m_div;
  logic        e_arm, e_abort;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment: UART rx buffer, UART transmitter, grant from the dump controller, monitors.
  always @(negedge clk) begin
    if (!rst) begin
      rxq.delete();
      uart_rxempty = 1'b1; uart_rxdata = 8'h00;
      uart_txempty = 1'b1; tx_cnt = 0;
      resp_gnt = 1'b0; gdly = 0;
      arm_prev = 1'b0; abort_prev = 1'b0; uld_prev = 1'b0;
    end else begin
      if (uart_uld_rx_data && rxq.size() > 0) void'(rxq.pop_front());
      uart_rxempty = (rxq.size() == 0);
      uart_rxdata  = (rxq.size() == 0) ? 8'h00 : rxq[0];
      if (!tx_hold) begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) uart_txempty = 1'b1;
        end else if (uart_ld_tx_data && uart_txempty) begin
          txq.push_back(uart_tx_data);
          uart_txempty = 1'b0;
          tx_cnt = $urandom_range(1, 6);
        end
      end
      if (!resp_req) begin
        resp_gnt = 1'b0;
        gdly = $urandom_range(0, 3);
      end else if (!resp_gnt) begin
        if (gdly == 0) resp_gnt = 1'b1; else gdly--;
      end
      if (uart_ld_tx_data && !resp_req) viol++;
      if (uart_uld_rx_data && uld_prev) viol++;
      if (arm && arm_prev) viol++;
      if (abort && abort_prev) viol++;
      if (arm) arm_cnt++;
      if (abort) abort_cnt++;
      arm_prev = arm; abort_prev = abort; uld_prev = uart_uld_rx_data;
    end
  end

  // Frame-level command semantics.
  task automatic model_frame(input logic [7:0] op, input logic [7:0] p0, input logic [7:0] p1,
                             input logic bad, input logic busy);
    exp_q.delete(); e_arm = 1'b0; e_abort = 1'b0;
    if (op < 8'd1 || op > 8'd5 || bad) begin
      exp_q.push_back(NAK);
      return;
    end
    case (op)
      8'd1: if (busy) exp_q.push_back(NAK); else begin m_mask = p0[2:0]; exp_q.push_back(ACK); end
      8'd2: if (busy || {p0, p1} == 16'd0) exp_q.push_back(NAK);
            else begin m_div = {p0, p1}; exp_q.push_back(ACK); end
      8'd3: if (busy) exp_q.push_back(NAK); else begin e_arm = 1'b1; exp_q.push_back(ACK); end
      8'd4: begin e_abort = 1'b1; exp_q.push_back(ACK); end
      default: begin exp_q.push_back(ACK); exp_q.push_back({busy, 4'b0000, m_mask}); end
    endcase
  endtask

  task automatic send_frame(input string tag, input logic [7:0] op, input logic [7:0] p0,
                            input logic [7:0] p1, input logic bad, input logic busy, input int junk);
    logic [7:0] chk;
    int len, n;
    len = (op == 8'h01) ? 1 : (op == 8'h02) ? 2 : 0;
    chk = op ^ ((len > 0) ? p0 : 8'h00) ^ ((len > 1) ? p1 : 8'h00);
    if (bad) chk = chk ^ 8'($urandom_range(1, 255));
    model_frame(op, p0, p1, bad, busy);
    capture_busy = busy;
    txq.delete(); arm_cnt = 0; abort_cnt = 0;
    for (int i = 0; i < junk; i++) rxq.push_back(8'($urandom_range(0, 8'hA4)));
    rxq.push_back(8'hA5);
    rxq.push_back(op);
    if (op >= 8'd1 && op <= 8'd5) begin
      if (len > 0) rxq.push_back(p0);
      if (len > 1) rxq.push_back(p1);
      rxq.push_back(chk);
    end
    n = 0;
    while (!(rxq.size() == 0 && txq.size() >= exp_q.size() && !resp_req && uart_txempty)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_eq({tag, "_done"}, 0, 1);
    repeat (2) @(negedge clk);
    check_eq({tag, "_nresp"}, txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
      check_eq({tag, "_resp"}, txq[i], exp_q[i]);
    check_eq({tag, "_mask"}, trig_mask, m_mask);
    check_eq({tag, "_div"}, samp_div, m_div);
    check_eq({tag, "_arm"}, arm_cnt, e_arm);
    check_eq({tag, "_abort"}, abort_cnt, e_abort);
  endtask

  initial begin
    int n, sel;
    logic [7:0] op, p0, p1;
    logic bad, busy;
    rst = 1'b0; tx_hold = 1'b0; capture_busy = 1'b0;
    uart_rxempty = 1'b1; uart_rxdata = 8'h00; uart_txempty = 1'b1; resp_gnt = 1'b0;
    m_mask = 3'b111; m_div = 16'd1;
    repeat (3) @(negedge clk);
    check_eq("rst_mask", trig_mask, 3'b111);
    check_eq("rst_div", samp_div, 16'd1);
    check_eq("rst_outs", {arm, abort, resp_req, uart_ld_tx_data, uart_uld_rx_data}, 5'b0);
    check_eq("rst_txdata", uart_tx_data, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send_frame("setmask", 8'h01, 8'h05, 8'h00, 1'b0, 1'b0, 0);
    send_frame("div0", 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    send_frame("div1234", 8'h02, 8'h12, 8'h34, 1'b0, 1'b0, 1);
    send_frame("arm_busy", 8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    send_frame("arm_idle", 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    send_frame("mask3", 8'h01, 8'h03, 8'h00, 1'b0, 1'b0, 0);
    send_frame("status", 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    send_frame("badchk", 8'h01, 8'h06, 8'h00, 1'b1, 1'b0, 0);
    send_frame("badop", 8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Partial frame then silence: dropped without any response.
    capture_busy = 1'b0; txq.delete();
    rxq.push_back(8'hA5); rxq.push_back(8'h01);
    n = 0;
    while (rxq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (TO + 5) @(negedge clk);
    check_eq("tmo_ntx", txq.size(), 0);
    check_eq("tmo_req", resp_req, 1'b0);
    check_eq("tmo_mask", trig_mask, m_mask);
    send_frame("abort", 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      sel  = $urandom_range(0, 6);
      op   = (sel == 0) ? 8'(8'h06 + $urandom_range(0, 200)) : 8'((sel > 5) ? 2 : sel);
      p0   = 8'($urandom_range(0, 255));
      p1   = 8'($urandom_range(0, 255));
      if (op == 8'h02 && $urandom_range(0, 3) == 0) begin p0 = 8'h00; p1 = 8'h00; end
      bad  = ($urandom_range(0, 4) == 0);
      busy = ($urandom_range(0, 2) == 0);
      send_frame("rand", op, p0, p1, bad, busy, $urandom_range(0, 2));
    end

    // Asynchronous reset while a response byte is being loaded.
    tx_hold = 1'b1;
    capture_busy = 1'b0;
    rxq.push_back(8'hA5); rxq.push_back(8'h05); rxq.push_back(8'h05);
    n = 0;
    while (!uart_ld_tx_data && n < 500) begin @(negedge clk); n++; end
    check_eq("pre_rst_ld", uart_ld_tx_data, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_mask", trig_mask, 3'b111);
    check_eq("arst_div", samp_div, 16'd1);
    check_eq("arst_outs", {arm, abort, resp_req, uart_ld_tx_data, uart_uld_rx_data}, 5'b0);
    check_eq("arst_txdata", uart_tx_data, 8'h00);
    tx_hold = 1'b0;
    m_mask = 3'b111; m_div = 16'd1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame("post_rst", 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 0);

    check_eq("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
